bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/bus_mem_responder.sv | 132 +++++++++++++
 tb/tb_bus_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_responder.sv
// Single-transaction bus responder backed by a 64-bit word store; 8-beat line reads and writes.
// Optional build macro BUS_RESP_CRITICAL_WORD_FIRST_EN: read beats start at the addressed word and wrap within the line.
module bus_mem_responder #(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int unsigned AW      = $clog2(MEM_WORDS);
    localparam int unsigned LAT_W   = 4;
    localparam int unsigned BEAT_W  = 3;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_DATA} state_t;

    state_t                     state;
    logic [AW-1:0]              base_idx;
    logic [BUS_TAG_WIDTH-1:0]   tag_q;
    logic [BEAT_W-1:0]          start_off;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [LAT_W-1:0]           lat_cnt;
    logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

    logic                       mem_we;
    logic [BEAT_W-1:0]          next_off;
    logic [BEAT_W-1:0]          req_off;

    // Acceptance must be same-cycle for write data beats, so the handshake is combinational.
    always_comb begin
        bus_reqack = 1'b0;
        mem_we     = 1'b0;
        if (!reset) begin
            bus_reqack = bus_reqcyc && (state == IDLE || state == WR_DATA);
            mem_we     = bus_reqcyc && (state == WR_DATA);
        end
        next_off = BEAT_W'(start_off + beat_cnt + BEAT_W'(1));
`ifdef BUS_RESP_CRITICAL_WORD_FIRST_EN
        req_off = bus_req[5:3];
`else
        req_off = '0;
`endif
    end

    // Store is never reset; partially written lines survive an abort.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[base_idx | AW'(beat_cnt)] <= bus_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bus_respcyc <= 1'b0;
            bus_resp    <= '0;
            bus_resptag <= '0;
            base_idx    <= '0;
            tag_q       <= '0;
            start_off   <= '0;
            beat_cnt    <= '0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus_reqcyc) begin
                        base_idx <= bus_req[3 +: AW] & ~AW'(7);
                        tag_q    <= bus_reqtag;
                        beat_cnt <= '0;
                        lat_cnt  <= '0;
                        if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
                            state     <= RD_WAIT;
                            start_off <= req_off;
                        end else begin
                            state     <= WR_DATA;
                            start_off <= '0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) begin
                        state       <= RD_RESP;
                        lat_cnt     <= '0;
                        beat_cnt    <= '0;
                        bus_respcyc <= 1'b1;
                        bus_resptag <= tag_q;
                        bus_resp    <= mem[base_idx | AW'(start_off)];
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                RD_RESP: begin
                    // Beat holds until consumed; the next word is fetched on the acknowledging edge.
                    if (bus_respack) begin
                        if (beat_cnt == BEAT_W'(7)) begin
                            state       <= IDLE;
                            beat_cnt    <= '0;
                            bus_respcyc <= 1'b0;
                            bus_resp    <= '0;
                            bus_resptag <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                            bus_resp <= mem[base_idx | AW'(next_off)];
                        end
                    end
                end
                WR_DATA: begin
                    if (bus_reqcyc) begin
                        if (beat_cnt == BEAT_W'(7)) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: line reads, backpressure, writes, critical word, reset abort, stalls.
module tb_bus_mem_responder;

    localparam int unsigned L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc;
    logic        bus_respack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_mem_responder #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_WORDS(4096), .READ_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    task automatic step();
        @(negedge clk);
    endtask

    // Present one request beat, expect a single-cycle ack; returns 1 cycle later with inputs idle.
    task automatic issue(input logic [63:0] addr, input logic [12:0] tag, input string nm);
        step();
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        #1;
        total++;
        if (bus_reqack !== 1'b1) begin
            bad++; $display("FAIL %s accept: reqack=%b want 1", nm, bus_reqack);
        end
        step();
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        #1;
        total++;
        if (bus_reqack !== 1'b0) begin
            bad++; $display("FAIL %s ack_one_cycle: reqack=%b want 0", nm, bus_reqack);
        end
    endtask

    // Collect 8 beats starting from cycle 1 after acceptance; optional 1,0,1,0 backpressure.
    task automatic collect(input logic [63:0] exp [8], input logic [12:0] tag,
                           input bit toggle, input bit chk_lat, input string nm);
        int c;
        bit pat;
        bit done;
        int hold;
        c = 1;
        pat = 1'b1;
        while (bus_respcyc !== 1'b1 && c < 40) begin
            step(); #1; c++;
        end
        if (chk_lat) begin
            total++;
            if (c != int'(L) + 1) begin
                bad++; $display("FAIL %s latency: first respcyc at %0d want %0d", nm, c, L + 1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            done = 1'b0;
            hold = 0;
            while (!done && hold < 4) begin
                bus_respack = toggle ? pat : 1'b1;
                total++;
                if (bus_respcyc !== 1'b1 || bus_resp !== exp[i] || bus_resptag !== tag) begin
                    bad++;
                    $display("FAIL %s beat%0d: cyc=%b data=%h tag=%h want cyc=1 data=%h tag=%h",
                             nm, i, bus_respcyc, bus_resp, bus_resptag, exp[i], tag);
                end
                total++;
                if (bus_reqack !== 1'b0) begin
                    bad++; $display("FAIL %s reqack_in_resp: got %b want 0", nm, bus_reqack);
                end
                done = bus_respack;
                pat = ~pat;
                hold++;
                step(); #1;
            end
        end
        bus_respack = 1'b0;
        total++;
        if (bus_respcyc !== 1'b0) begin
            bad++; $display("FAIL %s respcyc_drop: got %b want 0", nm, bus_respcyc);
        end
    endtask

    task automatic wait_resp(input string nm);
        int c;
        c = 0;
        while (bus_respcyc !== 1'b1 && c < 40) begin
            step(); #1; c++;
        end
        total++;
        if (bus_respcyc !== 1'b1) begin
            bad++; $display("FAIL %s wait_resp: respcyc=%b want 1", nm, bus_respcyc);
        end
    endtask

    task automatic check_zero(input string nm);
        total++;
        if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0 || bus_resp !== 64'h0 || bus_resptag !== 13'h0) begin
            bad++;
            $display("FAIL %s zero_outputs: ack=%b cyc=%b data=%h tag=%h want all 0",
                     nm, bus_reqack, bus_respcyc, bus_resp, bus_resptag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus_reqcyc = 1'b1; bus_req = 64'h1000; bus_reqtag = 13'h1005; bus_respack = 1'b0;
        step(); step(); #1;
        check_zero("reset");
        step();
        reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
    endtask

    task automatic test_read_basic();
        logic [63:0] e [8];
        for (int i = 0; i < 8; i++) e[i] = 64'h1000 + 64'(i);
        issue(64'h1000, 13'h1005, "read_basic");
        collect(e, 13'h1005, 1'b0, 1'b1, "read_basic");
    endtask

    task automatic test_read_backpressure();
        logic [63:0] e [8];
        for (int i = 0; i < 8; i++) e[i] = 64'h1000 + 64'(i);
        issue(64'h1000, 13'h1005, "read_bp");
        collect(e, 13'h1005, 1'b1, 1'b1, "read_bp");
    endtask

    task automatic test_write();
        logic [63:0] e [8];
        issue(64'h2000, 13'h0003, "write");
        for (int i = 0; i < 8; i++) begin
            step();
            bus_reqcyc = 1'b1; bus_req = 64'hA0 + 64'(i);
            #1;
            total++;
            if (bus_reqack !== 1'b1 || bus_respcyc !== 1'b0) begin
                bad++; $display("FAIL write data%0d: ack=%b cyc=%b want ack=1 cyc=0", i, bus_reqack, bus_respcyc);
            end
            step();
            bus_reqcyc = 1'b0; bus_req = '0;
            #1;
            total++;
            if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0) begin
                bad++; $display("FAIL write gap%0d: ack=%b cyc=%b want ack=0 cyc=0", i, bus_reqack, bus_respcyc);
            end
        end
        for (int i = 0; i < 8; i++) e[i] = 64'hA0 + 64'(i);
        issue(64'h2000, 13'h1003, "raw_read");
        collect(e, 13'h1003, 1'b0, 1'b1, "raw_read");
    endtask

    task automatic test_critical_word();
        logic [63:0] e [8];
        for (int i = 0; i < 8; i++) begin
`ifdef BUS_RESP_CRITICAL_WORD_FIRST_EN
            e[i] = 64'h1000 + 64'((i + 5) % 8);
`else
            e[i] = 64'h1000 + 64'(i);
`endif
        end
        issue(64'h1028, 13'h1011, "crit_word");
        collect(e, 13'h1011, 1'b0, 1'b1, "crit_word");
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] e [8];
        issue(64'h1000, 13'h1005, "rst_mid");
        wait_resp("rst_mid");
        bus_respack = 1'b1;
        step(); #1;
        step(); #1;
        total++;
        if (bus_resp !== 64'h1002) begin
            bad++; $display("FAIL rst_mid third_beat: data=%h want 0000000000001002", bus_resp);
        end
        reset = 1'b1; bus_reqcyc = 1'b1; bus_req = 64'h2000; bus_reqtag = 13'h1001;
        step(); #1;
        check_zero("rst_mid_a");
        step(); #1;
        check_zero("rst_mid_b");
        reset = 1'b0; bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
        for (int i = 0; i < 8; i++) e[i] = 64'h1000 + 64'(i);
        issue(64'h1000, 13'h1006, "rst_fresh");
        collect(e, 13'h1006, 1'b0, 1'b1, "rst_fresh");
    endtask

    task automatic test_back_to_back();
        logic [63:0] e [8];
        issue(64'h1000, 13'h1005, "b2b_first");
        wait_resp("b2b_first");
        bus_reqcyc = 1'b1; bus_req = 64'h2000; bus_reqtag = 13'h1ABC; bus_respack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b1 || bus_resp !== 64'h1000 + 64'(i)) begin
                bad++;
                $display("FAIL b2b stall%0d: ack=%b cyc=%b data=%h want ack=0 cyc=1 data=%h",
                         i, bus_reqack, bus_respcyc, bus_resp, 64'h1000 + 64'(i));
            end
            step(); #1;
        end
        bus_respack = 1'b0;
        total++;
        if (bus_reqack !== 1'b1 || bus_respcyc !== 1'b0) begin
            bad++; $display("FAIL b2b second_accept: ack=%b cyc=%b want ack=1 cyc=0", bus_reqack, bus_respcyc);
        end
        step();
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0;
        #1;
        for (int i = 0; i < 8; i++) e[i] = 64'hA0 + 64'(i);
        collect(e, 13'h1ABC, 1'b0, 1'b1, "b2b_second");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) dut.mem[512 + i] = 64'h1000 + 64'(i);
        test_reset();
        test_read_basic();
        test_read_backpressure();
        test_write();
        test_critical_word();
        test_reset_mid_read();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
